// File: rtl/fpnew_pkg.sv
// Shared fpnew types plus the decode-stage opcode constants, decoded bundle and rm check.
package fpnew_pkg;

    typedef enum logic [1:0] {
        RV32FNone   = 2'd0,
        RV32F       = 2'd1,
        RV64FDouble = 2'd2
    } rvf_e;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SGNJ   = 5'b00100;
    localparam logic [4:0] F5_MINMAX = 5'b00101;
    localparam logic [4:0] F5_F2F    = 5'b01000;
    localparam logic [4:0] F5_SQRT   = 5'b01011;
    localparam logic [4:0] F5_CMP    = 5'b10100;
    localparam logic [4:0] F5_F2I    = 5'b11000;
    localparam logic [4:0] F5_I2F    = 5'b11010;
    localparam logic [4:0] F5_MV_X   = 5'b11100;
    localparam logic [4:0] F5_MV_F   = 5'b11110;

    typedef struct packed {
        operation_e op;
        logic       op_mod;
        fp_format_e src_fmt;
        fp_format_e dst_fmt;
        roundmode_e rnd_mode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [4:0] rd;
        logic       fp_wb;
        logic       load;
        logic       store;
        logic       illegal;
    } fp_dec_bundle_t;

    localparam fp_dec_bundle_t DEC_BUNDLE_RST = '{
        op:       FMADD,
        op_mod:   1'b0,
        src_fmt:  FP32,
        dst_fmt:  FP32,
        rnd_mode: RNE,
        rs1:      5'd0,
        rs2:      5'd0,
        rs3:      5'd0,
        rd:       5'd0,
        fp_wb:    1'b0,
        load:     1'b0,
        store:    1'b0,
        illegal:  1'b0
    };

    // 101/110 are reserved encodings; 111 (DYN) is legal here and resolved against frm.
    function automatic logic is_valid_rm(input logic [2:0] rm);
        return (rm != 3'b101) && (rm != 3'b110);
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// 32-entry busy vector for outstanding FP register writes, with a same-cycle hazard lookup.
module fp_scoreboard
    import fpnew_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        set_i,
    input  logic [4:0]  set_addr_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_addr_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rs3_i,
    input  logic [4:0]  rd_i,
    input  logic        use_rs1_i,
    input  logic        use_rs2_i,
    input  logic        use_rs3_i,
    input  logic        use_rd_i,
    output logic        hazard_o,
    output logic [31:0] busy_o
);

    logic [31:0] busy_q;
    logic [31:0] set_oh;
    logic [31:0] clr_oh;
    logic [31:0] busy_eff;

    assign set_oh   = set_i ? (32'd1 << set_addr_i) : 32'd0;
    assign clr_oh   = clr_i ? (32'd1 << clr_addr_i) : 32'd0;
    // A writeback landing this cycle already frees its register for lookup.
    assign busy_eff = busy_q & ~clr_oh;

    assign hazard_o = (use_rs1_i & busy_eff[rs1_i]) |
                      (use_rs2_i & busy_eff[rs2_i]) |
                      (use_rs3_i & busy_eff[rs3_i]) |
                      (use_rd_i  & busy_eff[rd_i]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 32'd0;
        end else if (flush_i) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= (busy_q & ~clr_oh) | set_oh;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/fp_decode_stage.sv
// Registered FP decode stage: decodes F/D instructions, resolves rounding, stalls on FP hazards.
module fp_decode_stage
    import fpnew_pkg::*;
#(
    parameter rvf_e RVF = fpnew_pkg::RV64FDouble
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_rdata_i,
    input  logic [2:0]  frm_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output operation_e  dec_op_o,
    output logic        dec_op_mod_o,
    output fp_format_e  dec_src_fmt_o,
    output fp_format_e  dec_dst_fmt_o,
    output roundmode_e  dec_rnd_mode_o,
    output logic [4:0]  dec_rs1_o,
    output logic [4:0]  dec_rs2_o,
    output logic [4:0]  dec_rs3_o,
    output logic [4:0]  dec_rd_o,
    output logic        dec_fp_wb_o,
    output logic        dec_load_o,
    output logic        dec_store_o,
    output logic        dec_illegal_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_addr_i,
    output logic [31:0] busy_o
);

    logic [6:0]     opcode;
    logic [4:0]     funct5;
    logic [2:0]     rm;
    logic [1:0]     fmt_bits;
    logic           fp64_ok;
    fp_dec_bundle_t dec_d;
    fp_dec_bundle_t dec_q;
    logic           dec_valid_q;
    logic           use_rs1;
    logic           use_rs2;
    logic           use_rs3;
    logic           ill;
    logic           arith;
    logic           rm_is_sel;
    logic           fmt_ok;
    fp_format_e     fmt;
    logic           hazard;
    logic           accept;

    assign opcode   = instr_rdata_i[6:0];
    assign funct5   = instr_rdata_i[31:27];
    assign rm       = instr_rdata_i[14:12];
    assign fmt_bits = instr_rdata_i[26:25];
    assign fp64_ok  = (RVF == RV64FDouble);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec_d         = DEC_BUNDLE_RST;
        dec_d.rs1     = instr_rdata_i[19:15];
        dec_d.rs2     = instr_rdata_i[24:20];
        dec_d.rs3     = instr_rdata_i[31:27];
        dec_d.rd      = instr_rdata_i[11:7];
        dec_d.fp_wb   = 1'b1;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        use_rs3       = 1'b0;
        ill           = 1'b0;
        arith         = 1'b0;
        rm_is_sel     = 1'b0;

        if (opcode == OPC_LOAD_FP || opcode == OPC_STORE_FP) begin
            fmt_ok = (rm == 3'b010) || (rm == 3'b011 && fp64_ok);
            fmt    = rm[0] ? FP64 : FP32;
        end else begin
            fmt_ok = (fmt_bits == 2'b00) || (fmt_bits == 2'b01 && fp64_ok);
            fmt    = fmt_bits[0] ? FP64 : FP32;
        end
        dec_d.src_fmt = fmt;
        dec_d.dst_fmt = fmt;

        case (opcode)
            OPC_LOAD_FP: dec_d.load = 1'b1;
            OPC_STORE_FP: begin
                dec_d.store = 1'b1;
                dec_d.fp_wb = 1'b0;
                use_rs2     = 1'b1;
            end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                dec_d.op     = (opcode[3] == 1'b0) ? FMADD : FNMSUB;
                dec_d.op_mod = opcode[2];
                arith        = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                use_rs3      = 1'b1;
            end
            OPC_OP_FP: begin
                case (funct5)
                    F5_ADD, F5_SUB, F5_MUL, F5_DIV: begin
                        dec_d.op     = (funct5 == F5_MUL) ? MUL :
                                       (funct5 == F5_DIV) ? DIV : ADD;
                        dec_d.op_mod = (funct5 == F5_SUB);
                        arith        = 1'b1;
                        use_rs1      = 1'b1;
                        use_rs2      = 1'b1;
                    end
                    F5_SQRT: begin
                        dec_d.op = SQRT;
                        arith    = 1'b1;
                        use_rs1  = 1'b1;
                        ill      = (instr_rdata_i[24:20] != 5'd0);
                    end
                    F5_SGNJ, F5_MINMAX, F5_CMP: begin
                        dec_d.op    = (funct5 == F5_SGNJ)   ? SGNJ :
                                      (funct5 == F5_MINMAX) ? MINMAX : CMP;
                        dec_d.fp_wb = (funct5 != F5_CMP);
                        rm_is_sel   = 1'b1;
                        use_rs1     = 1'b1;
                        use_rs2     = 1'b1;
                        ill         = (funct5 == F5_MINMAX) ? (rm > 3'd1) : (rm > 3'd2);
                    end
                    F5_F2I, F5_I2F: begin
                        dec_d.op     = (funct5 == F5_F2I) ? F2I : I2F;
                        dec_d.op_mod = instr_rdata_i[20];
                        dec_d.fp_wb  = (funct5 == F5_I2F);
                        use_rs1      = (funct5 == F5_F2I);
                        arith        = 1'b1;
                        ill          = (instr_rdata_i[24:21] != 4'd0);
                    end
                    F5_F2F: begin
                        dec_d.op      = F2F;
                        dec_d.src_fmt = instr_rdata_i[20] ? FP64 : FP32;
                        arith         = 1'b1;
                        use_rs1       = 1'b1;
                        // Source must be a supported format and differ from the destination.
                        ill = (instr_rdata_i[24:22] != 3'd0) ||
                              (instr_rdata_i[21] != 1'b0) ||
                              (instr_rdata_i[20] && !fp64_ok) ||
                              (instr_rdata_i[21:20] == fmt_bits);
                    end
                    F5_MV_X: begin
                        dec_d.op    = (rm == 3'b001) ? CLASSIFY : SGNJ;
                        dec_d.fp_wb = 1'b0;
                        rm_is_sel   = 1'b1;
                        use_rs1     = 1'b1;
                        ill         = (instr_rdata_i[24:20] != 5'd0) || (rm > 3'd1);
                    end
                    F5_MV_F: begin
                        dec_d.op  = SGNJ;
                        rm_is_sel = 1'b1;
                        ill       = (instr_rdata_i[24:20] != 5'd0) || (rm != 3'd0);
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (arith) begin
            ill = ill || !is_valid_rm(rm) || (rm == 3'b111 && frm_i > 3'b100);
            dec_d.rnd_mode = roundmode_e'((rm == 3'b111) ? frm_i : rm);
        end else if (rm_is_sel) begin
            dec_d.rnd_mode = roundmode_e'(rm);
        end

        ill = ill || !fmt_ok || (RVF == RV32FNone);

        // Illegal instructions flow through without touching the scoreboard.
        if (ill) begin
            dec_d.illegal  = 1'b1;
            dec_d.fp_wb    = 1'b0;
            dec_d.rnd_mode = RNE;
            use_rs1        = 1'b0;
            use_rs2        = 1'b0;
            use_rs3        = 1'b0;
        end
    end

    fp_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .set_i      (accept & dec_d.fp_wb),
        .set_addr_i (dec_d.rd),
        .clr_i      (wb_valid_i),
        .clr_addr_i (wb_addr_i),
        .rs1_i      (dec_d.rs1),
        .rs2_i      (dec_d.rs2),
        .rs3_i      (dec_d.rs3),
        .rd_i       (dec_d.rd),
        .use_rs1_i  (instr_valid_i & use_rs1),
        .use_rs2_i  (instr_valid_i & use_rs2),
        .use_rs3_i  (instr_valid_i & use_rs3),
        .use_rd_i   (instr_valid_i & dec_d.fp_wb),
        .hazard_o   (hazard),
        .busy_o     (busy_o)
    );

    assign instr_ready_o = (~dec_valid_q | dec_ready_i) & ~hazard & ~flush_i;
    assign accept        = instr_valid_i & instr_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_valid_q <= 1'b0;
            dec_q       <= DEC_BUNDLE_RST;
        end else if (flush_i) begin
            dec_valid_q <= 1'b0;
            dec_q       <= DEC_BUNDLE_RST;
        end else if (accept) begin
            dec_valid_q <= 1'b1;
            dec_q       <= dec_d;
        end else if (dec_ready_i) begin
            dec_valid_q <= 1'b0;
            dec_q       <= DEC_BUNDLE_RST;
        end
    end

    assign dec_valid_o    = dec_valid_q;
    assign dec_op_o       = dec_q.op;
    assign dec_op_mod_o   = dec_q.op_mod;
    assign dec_src_fmt_o  = dec_q.src_fmt;
    assign dec_dst_fmt_o  = dec_q.dst_fmt;
    assign dec_rnd_mode_o = dec_q.rnd_mode;
    assign dec_rs1_o      = dec_q.rs1;
    assign dec_rs2_o      = dec_q.rs2;
    assign dec_rs3_o      = dec_q.rs3;
    assign dec_rd_o       = dec_q.rd;
    assign dec_fp_wb_o    = dec_q.fp_wb;
    assign dec_load_o     = dec_q.load;
    assign dec_store_o    = dec_q.store;
    assign dec_illegal_o  = dec_q.illegal;

endmodule
